// File: rtl/axis_arb_pkg.sv
// Shared types for the packet-level AXI-stream round-robin arbiter.
package axis_arb_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} arb_state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr_i, wrapping at N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 hit_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IW = $clog2(N);

    // Explicit wrap at N so non-power-of-two N never indexes past the last stream.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Walk offsets high to low so the lowest offset from the pointer wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[wrap_add(ptr_i, i)]) begin
                hit_o = 1'b1;
                idx_o = wrap_add(ptr_i, i);
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI-stream arbiter; grant is held until the last beat hands off.
// Optional per-stream completed-packet counters are enabled with ARB_STATS_EN.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N-1:0]         i_valid,
    output logic [N-1:0]         o_ready,
    input  logic [N*DW-1:0]      i_data,
    input  logic [N-1:0]         i_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DW-1:0]        o_data,
    output logic                 o_last,
    output logic                 o_busy,
    output logic [$clog2(N)-1:0] o_grant
`ifdef ARB_STATS_EN
    ,
    output logic [N*CNT_W-1:0]   o_pkt_cnt
`endif
);

    localparam int IW = $clog2(N);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          pick_hit;
    logic [IW-1:0] pick_idx;
    logic          last_xfer;

    rr_pick #(.N(N)) u_pick (
        .req_i (i_valid),
        .ptr_i (ptr_q),
        .hit_o (pick_hit),
        .idx_o (pick_idx)
    );

    assign last_xfer = (state_q == ARB_BUSY) && i_valid[grant_q] && i_ready && i_last[grant_q];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_hit) begin
                    state_d = ARB_BUSY;
                    grant_d = pick_idx;
                end
            end
            ARB_BUSY: begin
                if (last_xfer) begin
                    state_d = ARB_IDLE;
                    ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Zero-latency pass-through of the granted stream while BUSY.
    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        o_last  = 1'b0;
        o_ready = '0;
        if (state_q == ARB_BUSY) begin
            o_valid          = i_valid[grant_q];
            o_data           = i_data[grant_q*DW +: DW];
            o_last           = i_last[grant_q];
            o_ready[grant_q] = i_ready;
        end
        o_busy  = (state_q == ARB_BUSY);
        o_grant = grant_q;
    end

`ifdef ARB_STATS_EN
    logic [N-1:0][CNT_W-1:0] cnt_q;

    for (genvar k = 0; k < N; k++) begin : g_cnt
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                cnt_q[k] <= '0;
            end else if (last_xfer && (grant_q == IW'(k)) && (cnt_q[k] != {CNT_W{1'b1}})) begin
                cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end
    end

    assign o_pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter (N=4, DW=8): per-cycle model compare plus directed logs.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    typedef struct {
        int            g;
        logic [DW-1:0] d;
        logic          l;
        int            cyc;
    } obs_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    vld = '0;
    logic [N-1:0]    o_ready;
    logic [N*DW-1:0] dat = '0;
    logic [N-1:0]    lst = '0;
    logic            o_valid;
    logic            rdy = 1'b0;
    logic [DW-1:0]   o_data;
    logic            o_last;
    logic            o_busy;
    logic [1:0]      o_grant;
`ifdef ARB_STATS_EN
    logic [N*16-1:0] o_pkt_cnt;
`endif

    axis_rr_arbiter #(.N(N), .DW(DW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_valid (vld),
        .o_ready (o_ready),
        .i_data  (dat),
        .i_last  (lst),
        .o_valid (o_valid),
        .i_ready (rdy),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_busy  (o_busy),
        .o_grant (o_grant)
`ifdef ARB_STATS_EN
        ,
        .o_pkt_cnt (o_pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    bit    chk_en = 0;
    beat_t srcq[N][$];
    obs_t  obs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_busy  = 0;
    int m_grant = 0;
    int m_ptr   = 0;

    function automatic int first_from(input int p, input logic [N-1:0] req);
        for (int d = 0; d < N; d++)
            if (req[(p + d) % N]) return (p + d) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 0;
            m_grant <= 0;
            m_ptr   <= 0;
        end else if (!m_busy) begin
            if (vld != '0) begin
                m_busy  <= 1;
                m_grant <= first_from(m_ptr, vld);
            end
        end else if (vld[m_grant] && rdy && lst[m_grant]) begin
            m_busy <= 0;
            m_ptr  <= (m_grant + 1) % N;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0]  er;
        logic [DW-1:0] ed;
        logic          ev, el;
        if (chk_en) begin
            er = '0; ed = '0; ev = 1'b0; el = 1'b0;
            if (m_busy) begin
                ev = vld[m_grant];
                ed = dat[m_grant*DW +: DW];
                el = lst[m_grant];
                er[m_grant] = rdy;
            end
            chk("busy",  32'(o_busy),  32'(m_busy));
            chk("valid", 32'(o_valid), 32'(ev));
            chk("ready", 32'(o_ready), 32'(er));
            chk("data",  32'(o_data),  32'(ed));
            chk("last",  32'(o_last),  32'(el));
            if (m_busy) chk("grant", 32'(o_grant), 32'(m_grant));
        end
    end

    // ---------------- sources ----------------
    task automatic drive();
        for (int k = 0; k < N; k++) begin
            vld[k] = (srcq[k].size() > 0);
            dat[k*DW +: DW] = vld[k] ? srcq[k][0].d : '0;
            lst[k] = vld[k] ? srcq[k][0].l : 1'b0;
        end
    endtask

    task automatic push_pkt(input int k, input int nb, input logic [DW-1:0] base);
        for (int i = 0; i < nb; i++) srcq[k].push_back('{d: base + DW'(i), l: (i == nb - 1)});
    endtask

    // Handshakes are sampled on the falling edge, committed on the rising edge.
    task automatic tick();
        logic          ohs, r;
        logic [N-1:0]  ihs;
        obs_t          o;
        @(negedge clk);
        r   = rst;
        ohs = o_valid && rdy;
        ihs = vld & o_ready;
        o   = '{g: int'(o_grant), d: o_data, l: o_last, cyc: 0};
        @(posedge clk);
        cyc++;
        if (!r) begin
            if (ohs) begin
                o.cyc = cyc;
                obs.push_back(o);
            end
            for (int k = 0; k < N; k++) if (ihs[k]) void'(srcq[k].pop_front());
        end
        #1 drive();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    initial begin
        int c;
        drive();
        // Reset, then idle
        do_reset();
        chk("rst_busy",  32'(o_busy),  0);
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_data",  32'(o_data),  0);
        chk("rst_last",  32'(o_last),  0);
        chk_en = 1;
        ticks(10);

        // Single requester: stream 2, three beats
        obs.delete();
        rdy = 1'b1;
        c = cyc;
        push_pkt(2, 3, 8'h20);
        drive();
        tick();
        chk("t2_busy",  32'(o_busy),  1);
        chk("t2_grant", 32'(o_grant), 2);
        ticks(5);
        chk("t2_nbeats", obs.size(), 3);
        for (int i = 0; i < obs.size() && i < 3; i++) begin
            chk("t2_g",   obs[i].g,       2);
            chk("t2_d",   32'(obs[i].d),  32'(8'h20 + i));
            chk("t2_l",   32'(obs[i].l),  32'(i == 2));
            chk("t2_cyc", obs[i].cyc - c, 2 + i);
        end
        chk("t2_idle", 32'(o_busy), 0);

        // Fairness: four streams, two 2-beat packets each, from pointer 0
        do_reset();
        obs.delete();
        c = cyc;
        for (int k = 0; k < N; k++) begin
            push_pkt(k, 2, 8'(k * 16));
            push_pkt(k, 2, 8'(k * 16 + 2));
        end
        drive();
        ticks(30);
        chk("t3_nbeats", obs.size(), 16);
        for (int i = 0; i < obs.size() && i < 16; i++) begin
            int p;
            p = i / 2;
            chk("t3_g",   obs[i].g,       p % 4);
            chk("t3_d",   32'(obs[i].d),  (p % 4) * 16 + (p / 4) * 2 + (i % 2));
            chk("t3_l",   32'(obs[i].l),  i % 2);
            chk("t3_cyc", obs[i].cyc - c, 2 + p * 3 + (i % 2));
        end

        // Backpressure: stream 1 four beats, stream 3 waiting; ready 1,0,0,1
        obs.delete();
        c = cyc;
        push_pkt(1, 4, 8'hA0);
        push_pkt(3, 1, 8'hB0);
        drive();
        tick();
        chk("t4_grant", 32'(o_grant), 1);
        tick();
        for (int j = 0; j < 2; j++) begin
            rdy = 1'b0;
            #1;
            chk("t4_hold_d", 32'(o_data),  32'(8'hA1));
            chk("t4_hold_l", 32'(o_last),  0);
            chk("t4_hold_v", 32'(o_valid), 1);
            chk("t4_hold_r", 32'(o_ready), 0);
            tick();
        end
        rdy = 1'b1;
        ticks(6);
        chk("t4_nbeats", obs.size(), 5);
        if (obs.size() == 5) begin
            chk("t4_c0", obs[0].cyc - c, 2);
            chk("t4_d1", 32'(obs[1].d), 32'(8'hA1));
            chk("t4_c1", obs[1].cyc - c, 5);
            chk("t4_d3", 32'(obs[3].d), 32'(8'hA3));
            chk("t4_l3", 32'(obs[3].l), 1);
            chk("t4_c3", obs[3].cyc - c, 7);
            chk("t4_g4", obs[4].g, 3);
            chk("t4_d4", 32'(obs[4].d), 32'(8'hB0));
            chk("t4_c4", obs[4].cyc - c, 9);
        end

        // Reset mid-packet: stream 1 four beats, reset while beat 2 is presented
        obs.delete();
        c = cyc;
        push_pkt(1, 4, 8'hC0);
        drive();
        ticks(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy",  32'(o_busy),  0);
        chk("t5_valid", 32'(o_valid), 0);
        tick();
        chk("t5_regrant", 32'(o_grant), 1);
        ticks(5);
        chk("t5_nbeats", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("t5_c0", obs[0].cyc - c, 2);
            chk("t5_d1", 32'(obs[1].d), 32'(8'hC1));
            chk("t5_c1", obs[1].cyc - c, 5);
            chk("t5_l3", 32'(obs[3].l), 1);
        end

`ifdef ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) push_pkt(0, 1, 8'h10);
        for (int i = 0; i < 2; i++) push_pkt(3, 1, 8'h30);
        drive();
        ticks(20);
        chk("cnt0", 32'(o_pkt_cnt[0*16 +: 16]), 5);
        chk("cnt1", 32'(o_pkt_cnt[1*16 +: 16]), 0);
        chk("cnt2", 32'(o_pkt_cnt[2*16 +: 16]), 0);
        chk("cnt3", 32'(o_pkt_cnt[3*16 +: 16]), 2);
`endif

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
